// File: rtl/title_screen_driver.sv
// VGA raster generator and title-screen sequencer feeding the DAC with registered RGB/sync.
// Optional SCANLINE_EN halves every RGB channel on odd visible lines.
module title_screen_driver #(
    parameter int unsigned H_VISIBLE      = 640,
    parameter int unsigned H_SYNC_START   = 656,
    parameter int unsigned H_SYNC_END     = 752,
    parameter int unsigned H_TOTAL        = 800,
    parameter int unsigned V_VISIBLE      = 480,
    parameter int unsigned V_SYNC_START   = 490,
    parameter int unsigned V_SYNC_END     = 492,
    parameter int unsigned V_TOTAL        = 525,
    parameter int unsigned BLINK_FRAMES   = 32,
    parameter int unsigned CONFIRM_FRAMES = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pixel_en,
    input  logic       start_key,
    input  logic       game_over,
    input  logic       is_galaga,
    input  logic       is_press_start,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start,
    output logic       game_start,
    output logic       title_active
);

    localparam int unsigned FrameW = $clog2(BLINK_FRAMES);
    localparam int unsigned ConfW  = $clog2(CONFIRM_FRAMES + 1);

    typedef enum logic [1:0] {StTitle, StConfirm, StGame} state_e;

    state_e              state_q, state_d;
    logic [FrameW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [ConfW-1:0]    confirm_cnt_q, confirm_cnt_d;
    logic                sync1_q, sync2_q, key_prev_q;
    logic                start_edge, frame_tick, game_start_d, ps_visible;
    logic                visible, hs_d, vs_d;
    logic [7:0]          r_d, g_d, b_d;

    assign frame_tick = pixel_en && (DrawX == 10'(H_TOTAL - 1)) && (DrawY == 10'(V_TOTAL - 1));
    assign start_edge = sync2_q && !key_prev_q;
    assign title_active = (state_q != StGame);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            DrawX <= '0;
            DrawY <= '0;
        end else if (pixel_en) begin
            if (DrawX == 10'(H_TOTAL - 1)) begin
                DrawX <= '0;
                DrawY <= (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
            end else begin
                DrawX <= DrawX + 10'd1;
            end
        end
    end

    // Key synchronizer plus one extra flop for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            sync1_q    <= start_key;
            sync2_q    <= sync1_q;
            key_prev_q <= sync2_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StTitle;
            frame_cnt_q   <= '0;
            confirm_cnt_q <= '0;
            frame_start   <= 1'b0;
            game_start    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            confirm_cnt_q <= confirm_cnt_d;
            frame_start   <= frame_tick;
            game_start    <= game_start_d;
        end
    end

    // Transitions override the frame-counter increment when both land on one Clk.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_tick ? frame_cnt_q + FrameW'(1) : frame_cnt_q;
        confirm_cnt_d = confirm_cnt_q;
        game_start_d  = 1'b0;
        case (state_q)
            StTitle: begin
                if (start_edge) begin
                    state_d       = StConfirm;
                    frame_cnt_d   = '0;
                    confirm_cnt_d = '0;
                end
            end
            StConfirm: begin
                if (frame_tick) begin
                    if (confirm_cnt_q == ConfW'(CONFIRM_FRAMES - 1)) begin
                        state_d      = StGame;
                        game_start_d = 1'b1;
                    end else begin
                        confirm_cnt_d = confirm_cnt_q + ConfW'(1);
                    end
                end
            end
            StGame: begin
                if (game_over) begin
                    state_d     = StTitle;
                    frame_cnt_d = '0;
                end
            end
            default: state_d = StTitle;
        endcase
    end

    always_comb begin
        if (state_q == StConfirm) begin
            ps_visible = !frame_cnt_q[1];
        end else begin
            ps_visible = (frame_cnt_q < FrameW'(BLINK_FRAMES / 2));
        end
        visible = (DrawX < 10'(H_VISIBLE)) && (DrawY < 10'(V_VISIBLE));
        hs_d    = !((DrawX >= 10'(H_SYNC_START)) && (DrawX < 10'(H_SYNC_END)));
        vs_d    = !((DrawY >= 10'(V_SYNC_START)) && (DrawY < 10'(V_SYNC_END)));
        r_d     = 8'h00;
        g_d     = 8'h00;
        b_d     = 8'h00;
        if (visible && (state_q != StGame)) begin
            if (is_galaga) begin
                r_d = 8'hFF;
            end else if (is_press_start && ps_visible) begin
                r_d = 8'hFF;
                g_d = 8'hFF;
                b_d = 8'hFF;
            end
        end
`ifdef SCANLINE_EN
        if (DrawY[0]) begin
            r_d = r_d >> 1;
            g_d = g_d >> 1;
            b_d = b_d >> 1;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else if (pixel_en) begin
            VGA_HS      <= hs_d;
            VGA_VS      <= vs_d;
            VGA_BLANK_N <= visible;
            VGA_R       <= r_d;
            VGA_G       <= g_d;
            VGA_B       <= b_d;
        end
    end

endmodule

// File: tb/tb_title_screen_driver.sv
// Randomized bench for title_screen_driver with a pixel-count reference model.
// Raster is shrunk to 28x15 so that full blink/confirm sequences stay short.
module tb_title_screen_driver;

    localparam int HT = 28, HV = 20, HSS = 22, HSE = 25;
    localparam int VT = 15, VV = 10, VSS = 11, VSE = 13;
    localparam int BF = 32, CF = 16;

    logic       Clk = 0, Reset_n = 0, pixel_en = 0, start_key = 0, game_over = 0;
    logic       is_galaga = 0, is_press_start = 0;
    logic [9:0] DrawX, DrawY;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, game_start, title_active;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    int total = 0, bad = 0;

    title_screen_driver #(
        .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .BLINK_FRAMES(BF), .CONFIRM_FRAMES(CF)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .start_key(start_key),
        .game_over(game_over), .is_galaga(is_galaga), .is_press_start(is_press_start),
        .DrawX(DrawX), .DrawY(DrawY), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .frame_start(frame_start), .game_start(game_start), .title_active(title_active)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raster position, frames since last clear, and a mode number.
    int         mx, my, mframe, mstate, mconf;
    bit         kh0, kh1, kh2;
    logic       e_hs = 1, e_vs = 1, e_bl = 0, e_fs = 0, e_gs = 0;
    logic [7:0] e_r = 0, e_g = 0, e_b = 0;

    task automatic model_reset();
        mx = 0; my = 0; mframe = 0; mstate = 0; mconf = 0;
        kh0 = 0; kh1 = 0; kh2 = 0;
        e_hs = 1; e_vs = 1; e_bl = 0; e_r = 0; e_g = 0; e_b = 0; e_fs = 0; e_gs = 0;
    endtask

    task automatic model_step();
        bit sedge, tick, vis, psv;
        int n;
        sedge = kh1 && !kh2;
        tick  = pixel_en && mx == HT - 1 && my == VT - 1;
        e_fs  = tick;
        e_gs  = 0;
        if (pixel_en) begin
            vis  = (mx < HV) && (my < VV);
            e_hs = !(mx >= HSS && mx < HSE);
            e_vs = !(my >= VSS && my < VSE);
            e_bl = vis;
            psv  = (mstate == 0) ? ((mframe % BF) < BF / 2) : ((mframe % 4) < 2);
            e_r = 0; e_g = 0; e_b = 0;
            if (vis && mstate != 2) begin
                if (is_galaga) e_r = 8'hFF;
                else if (is_press_start && psv) begin
                    e_r = 8'hFF; e_g = 8'hFF; e_b = 8'hFF;
                end
`ifdef SCANLINE_EN
                if (my % 2 == 1) begin
                    e_r = e_r / 2; e_g = e_g / 2; e_b = e_b / 2;
                end
`endif
            end
            n  = (my * HT + mx + 1) % (HT * VT);
            mx = n % HT;
            my = n / HT;
        end
        if (tick) mframe = (mframe + 1) % BF;
        case (mstate)
            0: if (sedge) begin mstate = 1; mframe = 0; mconf = 0; end
            1: if (tick) begin
                mconf++;
                if (mconf == CF) begin mstate = 2; e_gs = 1; end
            end
            default: if (game_over) begin mstate = 0; mframe = 0; end
        endcase
        kh2 = kh1; kh1 = kh0; kh0 = start_key;
    endtask

    always @(posedge Clk) begin
        if (!Reset_n) model_reset();
        else model_step();
        #1;
        chk("drawx", DrawX, mx);
        chk("drawy", DrawY, my);
        chk("sync_blank", {VGA_HS, VGA_VS, VGA_BLANK_N}, {e_hs, e_vs, e_bl});
        chk("rgb", {VGA_R, VGA_G, VGA_B}, {e_r, e_g, e_b});
        chk("pulses", {frame_start, game_start, title_active}, {e_fs, e_gs, mstate != 2});
    end

    task automatic rand_cycle(input int pen_pct, input bit go_en);
        @(negedge Clk);
        pixel_en       = ($urandom_range(99) < pen_pct);
        is_galaga      = ($urandom_range(7) == 0);
        is_press_start = $urandom_range(1);
        game_over      = go_en && ($urandom_range(63) == 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_xy"}, {DrawX, DrawY}, 20'h0);
        chk({tag, "_sync"}, {VGA_HS, VGA_VS, VGA_BLANK_N}, 3'b110);
        chk({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk({tag, "_flags"}, {frame_start, game_start, title_active}, 3'b001);
    endtask

    initial begin
        int cyc, hs_lo, vs_lo, bl_hi, white, fs_cnt;
        @(negedge Clk);
        chk_reset_values("reset");
        @(negedge Clk);
        Reset_n  = 1;
        pixel_en = 1;

        // Line wrap right after reset with pixel_en held high.
        repeat (HT - 1) @(negedge Clk);
        chk("x_last", {DrawX, DrawY}, {10'd27, 10'd0});
        @(negedge Clk);
        chk("x_wrap", {DrawX, DrawY}, {10'd0, 10'd1});

        // One full frame window between consecutive frame_start pulses.
        cyc = 0;
        while (!frame_start && cyc < 1000) begin @(negedge Clk); cyc++; end
        chk("first_frame_seen", frame_start, 1'b1);
        cyc = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0;
        do begin
            @(negedge Clk);
            cyc++;
            if (!VGA_HS) hs_lo++;
            if (!VGA_VS) vs_lo++;
            if (VGA_BLANK_N) bl_hi++;
        end while (!frame_start && cyc < 1000);
        chk("frame_period", cyc, 420);
        chk("hs_low_count", hs_lo, 45);
        chk("vs_low_count", vs_lo, 56);
        chk("blank_n_count", bl_hi, 200);

        // Blink: 32 aligned frames in TITLE hold 16 white frames of 200 pixels.
        is_press_start = 1;
        white = 0;
        repeat (BF * HT * VT) begin
            @(negedge Clk);
            if ({VGA_R, VGA_G, VGA_B} == 24'hFFFFFF) white++;
        end
        chk("blink_white_pixels", white, 3200);

        // Random traffic, then a 3-Clk start press and the confirm countdown.
        repeat (300) rand_cycle(75, 1);
        rand_cycle(75, 1); start_key = 1;
        rand_cycle(75, 1);
        rand_cycle(75, 1);
        rand_cycle(75, 1); start_key = 0;
        fs_cnt = 0; cyc = 0;
        do begin
            rand_cycle(75, 1);
            cyc++;
            if (cyc == 500) start_key = 1;
            if (cyc == 503) start_key = 0;
            if (frame_start) fs_cnt++;
        end while (!game_start && cyc < 30000);
        chk("game_start_seen", game_start, 1'b1);
        chk("confirm_frames", fs_cnt, CF);
        chk("title_active_game", title_active, 1'b0);

        // Start press in GAME is ignored.
        game_over = 0;
        rand_cycle(75, 0); start_key = 1;
        repeat (3) rand_cycle(75, 0);
        start_key = 0;
        repeat (10) rand_cycle(75, 0);
        chk("press_in_game", title_active, 1'b0);

        rand_cycle(75, 0); game_over = 1;
        rand_cycle(75, 0);
        chk("game_over_return", title_active, 1'b1);
        repeat (1500) rand_cycle(75, 0);

        // Asynchronous reset in the middle of CONFIRM.
        rand_cycle(75, 0); start_key = 1;
        repeat (3) rand_cycle(75, 0);
        start_key = 0;
        repeat (900) rand_cycle(75, 0);
        #2 Reset_n = 0;
        #1 chk_reset_values("async_reset");
        @(negedge Clk);
        Reset_n = 1;
        repeat (2000) rand_cycle(75, 0);
        chk("after_reset_title", title_active, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/title_screen_driver.md
Name: title_screen_driver

Overview:
- Produces the 640x480 VGA raster coordinates (DrawX, DrawY) consumed by the title-screen logo renderers.
- Samples their hit flags (is_galaga, is_press_start) and drives registered RGB, sync and blank outputs.
- Runs the title-screen sequencer: blinking PRESS START, start-key confirmation, handoff to the game, and return on game over.
- Sits between the logo renderers and the VGA DAC at the top level.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_SYNC_START, 656, first HS-low column
H_SYNC_END, 752, first column after HS pulse
H_TOTAL, 800, columns per line
V_VISIBLE, 480, visible lines
V_SYNC_START, 490, first VS-low line
V_SYNC_END, 492, first line after VS pulse
V_TOTAL, 525, lines per frame
BLINK_FRAMES, 32, title blink period in frames (power of two, at least 4)
CONFIRM_FRAMES, 16, length of the CONFIRM state in frames

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous active-low reset
pixel_en  in  1  one-Clk pixel strobe (25 MHz rate); all raster state advances only when it is high
start_key  in  1  raw start button, active-high, asynchronous to Clk
game_over  in  1  one-Clk pulse from game logic
is_galaga  in  1  logo hit for the current DrawX/DrawY
is_press_start  in  1  PRESS START hit for the current DrawX/DrawY
DrawX  out  10  current column, 0..H_TOTAL-1
DrawY  out  10  current line, 0..V_TOTAL-1
VGA_HS  out  1  horizontal sync, active-low
VGA_VS  out  1  vertical sync, active-low
VGA_BLANK_N  out  1  high in the visible region
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
frame_start  out  1  one-Clk pulse at raster wrap
game_start  out  1  one-Clk pulse on entry to GAME
title_active  out  1  high in TITLE and CONFIRM

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - DrawX, DrawY, frame_cnt = 0; state = TITLE.
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, RGB = 0.
  - frame_start = 0, game_start = 0, title_active = 1; synchronizer flops = 0.
- Counters, on a Clk edge with pixel_en = 1:
  - DrawX increments; at H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps to 0 after V_TOTAL-1.
  - With pixel_en = 0, all raster state, outputs and FSM hold.
- frame_start is high for exactly one Clk, on the edge where DrawX = H_TOTAL-1, DrawY = V_TOTAL-1 and pixel_en = 1.
- frame_cnt (log2(BLINK_FRAMES) bits) increments on each frame_start and wraps.
- Output pipeline:
  - is_galaga and is_press_start are combinational functions of DrawX/DrawY and are sampled on the pixel_en edge.
  - VGA_HS, VGA_VS, VGA_BLANK_N and RGB are registered from the same pre-edge DrawX/DrawY, giving one pixel of latency, all mutually aligned.
  - HS is low while H_SYNC_START <= DrawX < H_SYNC_END; VS is low while V_SYNC_START <= DrawY < V_SYNC_END.
  - BLANK_N is high while DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Colour priority (visible region only; blanked pixels are RGB 0):
  - is_galaga: FF/00/00.
  - else is_press_start with ps_visible: FF/FF/FF.
  - else 00/00/00.
  - In GAME, RGB is always 0 (the game renderer owns the pixel mux).
- start_key: 2-flop synchronizer, then rising-edge detect. The edge is honoured only in TITLE and ignored in CONFIRM and GAME.
- FSM (transitions on Clk; frame events qualified by frame_start):
  - TITLE: ps_visible = (frame_cnt < BLINK_FRAMES/2). Start edge -> CONFIRM; clear confirm counter and frame_cnt.
  - CONFIRM: ps_visible = (frame_cnt[1] == 0), i.e. a 4-frame period. Counts frame_start pulses; on pulse number CONFIRM_FRAMES -> GAME, and game_start pulses in that same Clk.
  - GAME: title_active = 0. game_over -> TITLE; frame_cnt = 0.
  - game_over outside GAME is ignored.
  - frame_start coinciding with a transition: the transition wins; the counter clear takes precedence over the increment.

Optional Feature:
SCANLINE_EN
- Defined: on visible pixels where DrawY[0] = 1, each RGB channel is right-shifted by 1 (FF -> 7F) before registering. Timing and latency are unchanged.
- Undefined: no dimming; colours exactly as in Behaviour.

Test Plan:
- Reset release, pixel_en held high: DrawX reaches 799 then wraps to 0 while DrawY goes 0->1; HS low for exactly 96 pixel strobes per line; VS low for 2 lines; frame_start pulses once per 420000 strobes.
- is_galaga forced high at DrawX=300, DrawY=240: RGB = FF/00/00 one pixel later with BLANK_N = 1; the same stimulus at DrawX=700 gives RGB = 0, BLANK_N = 0.
- is_press_start held high in TITLE: white for frames 0-15, black for frames 16-31, repeating.
- 3-Clk start_key pulse: enters CONFIRM within 3 Clk; after 16 frame_start pulses, game_start pulses once and title_active = 0; a second start press in GAME has no effect.
- game_over pulse in GAME: TITLE on the next Clk, frame_cnt = 0, title_active = 1.
- Reset_n low at DrawX=400, DrawY=100 during CONFIRM: all outputs return to reset values immediately and state = TITLE.
